// File: rtl/qft_seq_ctrl_if.sv
// ============================================================================
// Module      : qft_seq_ctrl_if
// Description : Command/strobe bundle between the top-level command source,
//               the QFT sequencer and the MAC/abs datapath.
//               master : command source; drives the starts and abort and
//                        observes the indices, strobes and handshake.
//               slave  : sequencer; drives the indices, strobes, busy and done.
// Signals     : strt_qft, strt_abs, abort          (master -> slave)
//               row_idx, col_idx                   (slave -> master) [IDX_W]
//               clr_acc, w_en_mult, w_en_acc,
//               w_en_row, w_en_abs, update_state   (slave -> master)
//               busy, done                         (slave -> master)
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface qft_seq_ctrl_if #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
    logic             strt_qft;
    logic             strt_abs;
    logic             abort;
    logic [IDX_W-1:0] row_idx;
    logic [IDX_W-1:0] col_idx;
    logic             clr_acc;
    logic             w_en_mult;
    logic             w_en_acc;
    logic             w_en_row;
    logic             w_en_abs;
    logic             update_state;
    logic             busy;
    logic             done;

    modport master (
        output strt_qft, strt_abs, abort,
        input  row_idx, col_idx, clr_acc, w_en_mult, w_en_acc,
               w_en_row, w_en_abs, update_state, busy, done
    );

    modport slave (
        input  strt_qft, strt_abs, abort,
        output row_idx, col_idx, clr_acc, w_en_mult, w_en_acc,
               w_en_row, w_en_abs, update_state, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/qft_seq_ctrl.sv
// ============================================================================
// Module      : qft_seq_ctrl
// Description : Sequencer for the signed QFT datapath. Runs the N x N complex
//               matrix-vector product (clear, then multiply/accumulate per
//               column, then row write-back, then state commit) and the
//               element-wise magnitude pass. Moore outputs only.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - qft_seq_ctrl_if.slave (starts, abort, indices,
//                        datapath strobes, busy/done)
// Parameters  : N      - state-vector dimension (>= 1)
//               IDX_W  - index width
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module qft_seq_ctrl #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    qft_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_MULT = 3'd2,
        S_ACC  = 3'd3,
        S_WROW = 3'd4,
        S_UPD  = 3'd5,
        S_ABS  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // Last legal index; counters wrap to 0 here so they never reach N.
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] w_row_nxt;
    logic [IDX_W-1:0] w_col_nxt;
    logic             w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);

        // Abort overrides every transition, but only while a pass is running;
        // in IDLE a simultaneous start is still honoured.
        if (bus.abort && w_busy) begin
            w_state_nxt = S_IDLE;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // QFT has priority; a coincident strt_abs is discarded.
                    if (bus.strt_qft) begin
                        w_state_nxt = S_CLR;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                    end else if (bus.strt_abs) begin
                        w_state_nxt = S_ABS;
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                    end
                end
                S_CLR:  w_state_nxt = S_MULT;
                S_MULT: w_state_nxt = S_ACC;
                S_ACC: begin
                    if (r_col == c_LAST) begin
                        w_col_nxt   = '0;
                        w_state_nxt = S_WROW;
                    end else begin
                        w_col_nxt   = r_col + 1'b1;
                        w_state_nxt = S_MULT;
                    end
                end
                S_WROW: begin
                    if (r_row == c_LAST) begin
                        w_row_nxt   = '0;
                        w_state_nxt = S_UPD;
                    end else begin
                        w_row_nxt   = r_row + 1'b1;
                        w_state_nxt = S_CLR;
                    end
                end
                S_UPD:  w_state_nxt = S_DONE;
                S_ABS: begin
                    if (r_col == c_LAST) begin
                        w_col_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_col_nxt   = r_col + 1'b1;
                    end
                end
                S_DONE: w_state_nxt = S_IDLE;
                default: begin
                    w_state_nxt = S_IDLE;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            endcase
        end
    end

    // Row counter is only non-zero inside a QFT pass, so it doubles as the
    // "0 otherwise" row index.
    assign bus.row_idx      = r_row;
    assign bus.col_idx      = r_col;
    assign bus.clr_acc      = (r_state == S_CLR);
    assign bus.w_en_mult    = (r_state == S_MULT);
    assign bus.w_en_acc     = (r_state == S_ACC);
    assign bus.w_en_row     = (r_state == S_WROW);
    assign bus.w_en_abs     = (r_state == S_ABS);
    assign bus.update_state = (r_state == S_UPD);
    assign bus.busy         = w_busy;
    assign bus.done         = (r_state == S_DONE);

endmodule

`default_nettype wire
